// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the frame scheduler and its serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         DEF_PAT_W   = 3;
  localparam logic [2:0] DEF_PATTERN = 3'b101;

  // Width able to hold the largest possible non-overlapping match count in one frame.
  function automatic int cnt_width(input int frame_len, input int pat_w);
    return $clog2(frame_len / pat_w + 1);
  endfunction

endpackage

// File: rtl/nonoverlap_pat_det.sv
// Serial non-overlapping pattern detector; match pulse is registered one cycle after the completing bit.
module nonoverlap_pat_det
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic serin,
  output logic det_out
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              det_q, det_d;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = {hist_q[PAT_W-2:0], serin};
      fill_d = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
      // Emptying the fill count after a hit stops the next match reusing these bits.
      if (fill_d == FILL_W'(PAT_W) && hist_d == PATTERN) begin
        det_d  = 1'b1;
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  assign det_out = det_q;

endmodule

// File: rtl/seq_det_frame_scheduler.sv
// Round-robin scheduler feeding one channel's latched frame at a time, MSB-first, into a shared detector.
// state | meaning
// IDLE  | waiting for any request; arbitrates and latches the winner's frame
// SHIFT | presenting FRAME_LEN frame bits to the detector
// DRAIN | catching the detector pulse from the final bit
// DONE  | result presented on done/done_ch/match_cnt
module seq_det_frame_scheduler
  import seq_det_pkg::*;
#(
  parameter int               NCH       = 4,
  parameter int               FRAME_LEN = 8,
  parameter int               PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN   = DEF_PATTERN,
  localparam int              CH_W      = $clog2(NCH),
  localparam int              CNT_W     = cnt_width(FRAME_LEN, PAT_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*FRAME_LEN-1:0] frame_in,
  output logic [NCH-1:0]           ack,
  output logic                     busy,
  output logic [CH_W-1:0]          gnt_ch,
  output logic                     ser_out,
  output logic                     det_out,
  output logic                     done,
  output logic [CH_W-1:0]          done_ch,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int BC_W = $clog2(FRAME_LEN);

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   sr_q, sr_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       run_q, run_d;
  logic [CH_W-1:0]        last_q, last_d;
  logic [CH_W-1:0]        gnt_q, gnt_d;
  logic [NCH-1:0]         ack_q, ack_d;
  logic                   done_q, done_d;
  logic [CH_W-1:0]        done_ch_q, done_ch_d;
  logic [CNT_W-1:0]       match_q, match_d;
  logic                   det_clr, det_en;
  logic [CH_W-1:0]        winner;

  // First set request strictly after prev_ch, wrapping; only meaningful when any request is set.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NCH-1:0] reqs,
                                              input logic [CH_W-1:0] prev_ch);
    logic [CH_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(prev_ch) + i) % NCH;
      if (reqs[idx] && !found) begin
        pick  = CH_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(req, last_q);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    run_d     = run_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    done_d    = 1'b0;
    done_ch_d = done_ch_q;
    match_d   = match_q;
    det_clr   = 1'b0;
    det_en    = 1'b0;

    if (det_out && (state_q == ST_SHIFT || state_q == ST_DRAIN) && run_q != '1)
      run_d = run_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_SHIFT;
          sr_d      = frame_in[winner*FRAME_LEN +: FRAME_LEN];
          gnt_d     = winner;
          last_d    = winner;
          ack_d     = NCH'(1) << winner;
          bit_cnt_d = '0;
          run_d     = '0;
          det_clr   = 1'b1;
        end
      end
      ST_SHIFT: begin
        det_en    = 1'b1;
        sr_d      = {sr_q[FRAME_LEN-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BC_W'(FRAME_LEN - 1))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d   = ST_DONE;
        done_d    = 1'b1;
        done_ch_d = gnt_q;
        match_d   = run_d;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      run_q     <= '0;
      last_q    <= CH_W'(NCH - 1);
      gnt_q     <= '0;
      ack_q     <= '0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      run_q     <= run_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      match_q   <= match_d;
    end
  end

  nonoverlap_pat_det #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (det_clr),
    .en      (det_en),
    .serin   (ser_out),
    .det_out (det_out)
  );

  assign ack       = ack_q;
  assign busy      = (state_q != ST_IDLE);
  assign gnt_ch    = gnt_q;
  assign ser_out   = (state_q == ST_SHIFT) & sr_q[FRAME_LEN-1];
  assign done      = done_q;
  assign done_ch   = done_ch_q;
  assign match_cnt = match_q;

endmodule
